or_eventos_n: RTL
=================

Name: or_eventos_n

Overview:
- Parametrised event aggregator for the RTC: N asynchronous flag inputs (alarm, timer, button, ...) are synchronised, optionally edge-detected, and latched into sticky per-channel pending bits.
- Software masks and clears the pending bits; a registered OR of the unmasked pending bits drives the interrupt/attention line to the control FSM.
- It generalises the fixed 3-input combinational OR into an N-channel, maskable, clearable, registered block.

Parameters:
- N_ENTRADAS, 3, number of input channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- MODO_FLANCO, 1, 1 = rising-edge events, 0 = level events.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- datos  input  N_ENTRADAS  raw asynchronous event inputs.
- mascara  input  N_ENTRADAS  1 = channel enabled toward salida (synchronous to clk).
- limpiar  input  N_ENTRADAS  1-cycle-or-longer clear strobe per channel (synchronous to clk).
- pendientes  output  N_ENTRADAS  sticky pending bits, registered.
- salida  output  1  registered OR of (pendientes & mascara).
- salida_pulso  output  1  one-cycle pulse on the 0→1 transition of salida.

Behaviour:
- Reset is asynchronous and active-high: every synchroniser flop, the edge-history flop, pendientes, salida and salida_pulso go to 0 immediately and stay 0 while reset=1.
- Synchroniser: channel i passes through SYNC_STAGES flops. s_i is the last stage; prev_i is s_i delayed by one cycle.
- Event definition:
  - MODO_FLANCO=1: ev_i = s_i & ~prev_i.
  - MODO_FLANCO=0: ev_i = s_i.
- Pending update, each edge, per bit: pendientes_i <= ev_i | (pendientes_i & ~limpiar_i).
  - Set wins over clear in the same cycle, so no event is lost.
- Latency, with datos_i first sampled high at edge t:
  - pendientes_i = 1 after edge t+SYNC_STAGES.
  - salida = 1 after edge t+SYNC_STAGES+1, if mascara_i=1.
- salida <= |(pendientes & mascara).
  - Masking never clears pendientes; a bit masked then unmasked reasserts salida one cycle after unmask.
- salida_pulso <= next_salida & ~salida. It is high exactly one cycle, in the same cycle salida first reads 1.
  - No new pulse while salida stays high, even if more channels become pending.
- Edge mode:
  - A held-high input produces exactly one event per rising edge. Pulses shorter than one clk period may be missed; the minimum guaranteed pulse width is 2 clk periods.
  - After reset release with an input already high, prev_i=0, so one event is generated. This is intentional and reports the pre-existing condition.
- Level mode: while s_i=1, clearing has no lasting effect; the bit re-sets the same cycle.
- Clearing a non-pending bit has no effect. Clearing all bits drops salida one cycle later; salida_pulso stays 0.
- Reset asserted mid-operation discards all pending events; no pulse on release unless inputs qualify anew.
- No combinational path from any input to any output.

Decomposition:
- Shared package rtc_pkg: defaults RTC_N_EVENTOS=3 and RTC_SYNC_STAGES=2, plus channel index constants (EV_ALARMA=0, EV_TIMER=1, EV_BOTON=2).
- One sub-module, sincronizador_flanco: 1-bit synchroniser + prev flop + edge/level select, outputting ev. It is instantiated N_ENTRADAS times in a generate loop. The top holds pendientes, salida and salida_pulso.

Test Plan (N_ENTRADAS=3, SYNC_STAGES=2, MODO_FLANCO=1, mascara=3'b111 unless stated):
- Reset/latency: reset then release with datos=0, then datos[1] high at edge 10 → pendientes=3'b010 after edge 12, salida=1 after edge 13 with salida_pulso=1 for that cycle only, pendientes stays 3'b010 with datos held high.
- Mask: mascara=3'b101, datos[1] pulse → pendientes=3'b010 and salida stays 0; then set mascara=3'b111 → salida=1 and salida_pulso=1 one cycle later.
- Clear vs. set collision: pendientes[0]=1; drive limpiar[0]=1 in the same cycle a new ev_0 occurs → pendientes[0] remains 1. Clear alone on the next cycle → 0, then salida=0 one cycle after that.
- Multiple channels: datos[0] rises, then datos[2] rises 5 cycles later → only one salida_pulso, pendientes=3'b101. Clearing 3'b001 keeps salida=1; clearing 3'b100 drops it.
- Reset mid-operation: pendientes=3'b111, salida=1, assert reset asynchronously between edges → all outputs 0 immediately. Release with datos=3'b000 → outputs stay 0.
- Level mode (MODO_FLANCO=0): hold datos[2]=1 and pulse limpiar[2] → pendientes[2] stays 1. Drop datos[2] and wait 3 cycles, then limpiar[2] → 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared RTC constants: default event-channel count, default synchroniser
// depth, and the fixed channel assignment of the RTC event sources.
package rtc_pkg;

  localparam int RTC_N_EVENTOS   = 3;
  localparam int RTC_SYNC_STAGES = 2;

  // Channel index of each RTC event source inside datos/pendientes.
  localparam int EV_ALARMA = 0;
  localparam int EV_TIMER  = 1;
  localparam int EV_BOTON  = 2;

endpackage : rtc_pkg

// File: rtl/sincronizador_flanco.sv
// sincronizador_flanco
// One event channel: brings an asynchronous flag into the clk domain through
// a chain of SYNC_STAGES flops and turns it into a one-clock event.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   dato   - raw asynchronous flag
//   ev     - event, rising edge of the synchronised flag (MODO_FLANCO=1)
//            or the synchronised level itself (MODO_FLANCO=0)
module sincronizador_flanco #(
  parameter int SYNC_STAGES = 2,
  parameter bit MODO_FLANCO = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic dato,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sinc;

  assign sinc = sync_q[SYNC_STAGES-1];

  // Shift chain for metastability settling, plus a one-cycle history of the
  // settled value for edge detection. prev_q clears on reset, so an input
  // already high at release reports one event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dato};
      prev_q <= sinc;
    end
  end

  assign ev = MODO_FLANCO ? (sinc & ~prev_q) : sinc;

endmodule : sincronizador_flanco

// File: rtl/or_eventos_n.sv
// or_eventos_n
// N-channel RTC event aggregator: synchronises each raw flag, latches its
// events into sticky pending bits, and raises a registered attention line
// (plus a one-cycle pulse on its rising edge) when any unmasked bit is pending.
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   datos        - raw asynchronous event inputs
//   mascara      - per-channel enable toward salida
//   limpiar      - per-channel clear strobe for pendientes
//   pendientes   - sticky pending bits
//   salida       - registered OR of unmasked pending bits
//   salida_pulso - one-cycle pulse when salida goes 0 -> 1
module or_eventos_n
  import rtc_pkg::*;
#(
  parameter int N_ENTRADAS  = RTC_N_EVENTOS,
  parameter int SYNC_STAGES = RTC_SYNC_STAGES,
  parameter bit MODO_FLANCO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_ENTRADAS-1:0] datos,
  input  logic [N_ENTRADAS-1:0] mascara,
  input  logic [N_ENTRADAS-1:0] limpiar,
  output logic [N_ENTRADAS-1:0] pendientes,
  output logic                  salida,
  output logic                  salida_pulso
);

  logic [N_ENTRADAS-1:0] ev;
  logic [N_ENTRADAS-1:0] pend_q, pend_d;
  logic                  salida_q, salida_d;
  logic                  pulso_q, pulso_d;

  for (genvar i = 0; i < N_ENTRADAS; i++) begin : g_canal
    sincronizador_flanco #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODO_FLANCO (MODO_FLANCO)
    ) u_sinc (
      .clk   (clk),
      .reset (reset),
      .dato  (datos[i]),
      .ev    (ev[i])
    );
  end

  // A new event has priority over a clear in the same cycle, so an event
  // arriving while software is clearing the old one is never lost.
  always_comb begin
    pend_d   = ev | (pend_q & ~limpiar);
    salida_d = |(pend_q & mascara);
    pulso_d  = salida_d & ~salida_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= '0;
      salida_q <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      salida_q <= salida_d;
      pulso_q  <= pulso_d;
    end
  end

  assign pendientes   = pend_q;
  assign salida       = salida_q;
  assign salida_pulso = pulso_q;

endmodule : or_eventos_n
